// File: rtl/synth_pkg.sv
// synth_pkg: shared widths, envelope limit and envelope state encoding for the synth datapath.
package synth_pkg;
    localparam int SAMPLE_WIDTH = 24;
    localparam int ENV_WIDTH = 16;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_state_t;
endpackage

// File: rtl/env_tick_gen.sv
// env_tick_gen: free-running divider producing a one-cycle envelope tick strobe.
// Ports: clk_in (clock), rst_in (async active-low reset), tick (high for one cycle
// every CYCLES_PER_TICK cycles, in the cycle the counter wraps).
module env_tick_gen #(
    parameter int CYCLES_PER_TICK = 2268
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick
);
    localparam int CW = CYCLES_PER_TICK > 1 ? $clog2(CYCLES_PER_TICK) : 1;
    logic [CW-1:0] count;
    assign tick = count == CW'(CYCLES_PER_TICK - 1);
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) count <= '0;
        else         count <= tick ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR amplitude envelope scaling signed oscillator samples.
// Ports: clk_in/rst_in (clock, async active-low reset), gate_in (note gate),
// velocity_in (MIDI velocity), attack_step/decay_step/sustain_level/release_step
// (envelope shape), sample_in -> sample_out (signed samples, 2-cycle latency),
// env_level_out (current envelope), busy_out (state != IDLE).
// Option ADSR_VELOCITY_EN: scales the envelope by (velocity+1)/128 in an extra
// register stage; sample latency becomes 3 cycles.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int CYCLES_PER_TICK = 2268
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           gate_in,
    input  logic [6:0]                     velocity_in,
    input  logic [ENV_WIDTH-1:0]           attack_step,
    input  logic [ENV_WIDTH-1:0]           decay_step,
    input  logic [ENV_WIDTH-1:0]           sustain_level,
    input  logic [ENV_WIDTH-1:0]           release_step,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic [ENV_WIDTH-1:0]           env_level_out,
    output logic                           busy_out
);
    logic tick;
    env_state_t state;
    logic [ENV_WIDTH-1:0] env, env_eff;
    logic signed [SAMPLE_WIDTH-1:0] sample_d;
    logic signed [SAMPLE_WIDTH+ENV_WIDTH:0] prod;
    logic gate_q, gate_d, on_pend, off_pend;
    logic [ENV_WIDTH:0] att_sum, dec_diff, rel_diff;
    logic att_done, dec_done, rel_done;

    env_tick_gen #(.CYCLES_PER_TICK(CYCLES_PER_TICK)) u_tick (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .tick  (tick)
    );

    // 17-bit arithmetic: the carry/borrow bit flags saturation
    assign att_sum  = {1'b0, env} + {1'b0, attack_step};
    assign dec_diff = {1'b0, env} - {1'b0, decay_step};
    assign rel_diff = {1'b0, env} - {1'b0, release_step};
    assign att_done = attack_step == '0 || att_sum >= {1'b0, ENV_MAX};
    assign dec_done = decay_step == '0 || dec_diff[ENV_WIDTH] || dec_diff[ENV_WIDTH-1:0] <= sustain_level;
    assign rel_done = release_step == '0 || rel_diff[ENV_WIDTH] || rel_diff[ENV_WIDTH-1:0] == '0;
    assign env_level_out = env;

    // Edge flags persist until the next tick so sub-tick gate pulses still register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            gate_q   <= 1'b0;
            gate_d   <= 1'b0;
            on_pend  <= 1'b0;
            off_pend <= 1'b0;
        end else begin
            gate_q   <= gate_in;
            gate_d   <= gate_q;
            on_pend  <= (on_pend & ~tick) | (gate_q & ~gate_d);
            off_pend <= (off_pend & ~tick) | (~gate_q & gate_d);
        end
    end

    // Transition ticks keep env unchanged; stepping starts on the following tick
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            env      <= '0;
            busy_out <= 1'b0;
        end else if (tick) begin
            if (on_pend && off_pend) begin
                state    <= RELEASE;
                busy_out <= 1'b1;
            end else if (on_pend) begin
                state    <= ATTACK;
                busy_out <= 1'b1;
            end else if (off_pend && state inside {ATTACK, DECAY, SUSTAIN}) begin
                state    <= RELEASE;
                busy_out <= 1'b1;
            end else begin
                case (state)
                    ATTACK: begin
                        env <= att_done ? ENV_MAX : att_sum[ENV_WIDTH-1:0];
                        if (att_done) state <= DECAY;
                    end
                    DECAY: begin
                        env <= dec_done ? sustain_level : dec_diff[ENV_WIDTH-1:0];
                        if (dec_done) state <= SUSTAIN;
                    end
                    SUSTAIN: env <= sustain_level;
                    RELEASE: begin
                        env <= rel_done ? '0 : rel_diff[ENV_WIDTH-1:0];
                        if (rel_done) begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ADSR_VELOCITY_EN
    logic [6:0] vel;
    // sample is delayed alongside env_eff so both meet at the multiplier
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vel      <= '0;
            env_eff  <= '0;
            sample_d <= '0;
        end else begin
            if (tick && on_pend) vel <= velocity_in;
            env_eff  <= ENV_WIDTH'(({8'b0, env} * ({17'b0, vel} + 24'd1)) >> 7);
            sample_d <= sample_in;
        end
    end
`else
    logic unused_velocity;
    assign unused_velocity = ^velocity_in;
    assign env_eff  = env;
    assign sample_d = sample_in;
`endif

    // |result| <= |sample|, so the truncation to SAMPLE_WIDTH cannot overflow
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prod       <= '0;
            sample_out <= '0;
        end else begin
            prod       <= sample_d * $signed({1'b0, env_eff});
            sample_out <= SAMPLE_WIDTH'(prod >>> ENV_WIDTH);
        end
    end
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed scoreboard bench for adsr_envelope with a 4-cycle envelope tick.
module tb_adsr_envelope;
    localparam int CPT = 4;
    localparam int VEL = 63;
`ifdef ADSR_VELOCITY_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic gate = 1'b0;
    logic [6:0] velocity = 7'(VEL);
    logic [15:0] attack = '0, decay = '0, sustain = '0, rel_step = '0;
    logic signed [23:0] sample_in = 24'sh400000;
    logic signed [23:0] sample_out;
    logic [15:0] env_level;
    logic busy;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    exp_t env_q[$];
    exp_t smp_q[$];

    adsr_envelope #(.CYCLES_PER_TICK(CPT)) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .gate_in      (gate),
        .velocity_in  (velocity),
        .attack_step  (attack),
        .decay_step   (decay),
        .sustain_level(sustain),
        .release_step (rel_step),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .env_level_out(env_level),
        .busy_out     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [23:0] scale(input int s, input logic [15:0] e);
        longint p;
        logic [15:0] ee;
`ifdef ADSR_VELOCITY_EN
        ee = 16'((32'(e) * 32'(VEL + 1)) >> 7);
`else
        ee = e;
`endif
        p = longint'(s) * longint'(ee);
        return 24'(p >>> 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_env(input string tag, input logic [15:0] v);
        env_q.push_back('{tag, {16'h0, v}});
    endtask

    task automatic pop_chk(input bit is_env, input logic [31:0] obs);
        exp_t e;
        if (is_env ? env_q.size() == 0 : smp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL empty_queue: observed %h expected none", obs);
        end else begin
            e = is_env ? env_q.pop_front() : smp_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    // Advance to 1 ns after the next envelope-update edge
    task automatic next_tick();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % CPT != 0);
    endtask

    task automatic tick_env();
        next_tick();
        pop_chk(1'b1, {16'h0, env_level});
    endtask

    task automatic samp(input int s, input logic [15:0] e, input string tag);
        sample_in = 24'(s);
        smp_q.push_back('{tag, {8'h0, scale(s, e)}});
        repeat (LAT) @(posedge clk);
        #1;
        pop_chk(1'b0, {8'h0, sample_out});
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vals[8] = '{32'sh400000, -32'sh400000, 32'sh7FFFFF, -32'sh800000,
                        32'sh123456, -1, 0, 1};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_env", {16'h0, env_level}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_sample", {8'h0, sample_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // attack / decay / sustain
        attack = 16'h4000; decay = 16'h1000; sustain = 16'h8000; rel_step = 16'h2000;
        next_tick();
        gate = 1'b1;
        push_env("atk_entry", 16'h0000);
        push_env("atk_1", 16'h4000);
        push_env("atk_2", 16'h8000);
        push_env("atk_3", 16'hC000);
        push_env("atk_max", 16'hFFFF);
        tick_env();
        chk("busy_attack", {31'h0, busy}, 32'h1);
        repeat (4) tick_env();
        samp(-32'sh400000, 16'hFFFF, "neg_full_env");
        for (int k = 1; k <= 7; k++) push_env("decay", 16'(16'hFFFF - k * 16'h1000));
        push_env("decay_floor", 16'h8000);
        push_env("sustain_hold", 16'h8000);
        repeat (9) tick_env();
        for (int i = 0; i < 8 + LAT - 1; i++) begin
            if (i < 8) begin
                sample_in = 24'(vals[i]);
                smp_q.push_back('{"stream", {8'h0, scale(vals[i], 16'h8000)}});
            end
            @(posedge clk);
            #1;
            if (i + 1 >= LAT) pop_chk(1'b0, {8'h0, sample_out});
        end

        // release to idle
        next_tick();
        gate = 1'b0;
        push_env("rel_entry", 16'h8000);
        push_env("rel_1", 16'h6000);
        push_env("rel_2", 16'h4000);
        push_env("rel_3", 16'h2000);
        push_env("rel_zero", 16'h0000);
        tick_env();
        chk("busy_release", {31'h0, busy}, 32'h1);
        repeat (4) tick_env();
        chk("busy_idle", {31'h0, busy}, 32'h0);

        // zero steps, live sustain, retrigger during release
        attack = 16'h0; decay = 16'h0; sustain = 16'h3000; rel_step = 16'h1000;
        gate = 1'b1;
        push_env("z_entry", 16'h0000);
        push_env("z_attack", 16'hFFFF);
        push_env("z_decay", 16'h3000);
        repeat (3) tick_env();
        sustain = 16'h2000;
        push_env("sus_live_lo", 16'h2000);
        tick_env();
        sustain = 16'h3000;
        push_env("sus_live_hi", 16'h3000);
        tick_env();
        gate = 1'b0;
        push_env("retrig_rel_entry", 16'h3000);
        tick_env();
        gate = 1'b1;
        attack = 16'h4000;
        push_env("retrig_hold", 16'h3000);
        push_env("retrig_step", 16'h7000);
        repeat (2) tick_env();
        gate = 1'b0;
        rel_step = 16'h0;
        push_env("rel0_entry", 16'h7000);
        push_env("rel0_zero", 16'h0000);
        repeat (2) tick_env();
        chk("busy_rel0_idle", {31'h0, busy}, 32'h0);

        // one-cycle gate pulse between ticks
        gate = 1'b1;
        @(posedge clk);
        #1;
        gate = 1'b0;
        push_env("pulse_release", 16'h0000);
        tick_env();
        chk("busy_pulse_rel", {31'h0, busy}, 32'h1);
        push_env("pulse_idle", 16'h0000);
        tick_env();
        chk("busy_pulse_idle", {31'h0, busy}, 32'h0);

        // reset in the middle of release
        attack = 16'h0; decay = 16'h0; sustain = 16'h5000; rel_step = 16'h1000;
        gate = 1'b1;
        push_env("pre_entry", 16'h0000);
        push_env("pre_attack", 16'hFFFF);
        push_env("pre_sustain", 16'h5000);
        repeat (3) tick_env();
        gate = 1'b0;
        push_env("pre_rel_entry", 16'h5000);
        push_env("pre_rel_step", 16'h4000);
        repeat (2) tick_env();
        samp(32'sh400000, 16'h4000, "pre_reset_sample");
        rst_n = 1'b0;
        #1;
        chk("async_reset_env", {16'h0, env_level}, 32'h0);
        chk("async_reset_busy", {31'h0, busy}, 32'h0);
        chk("async_reset_sample", {8'h0, sample_out}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
